// File: rtl/flag_pkg.sv
// ============================================================================
// flag_pkg : shared types and helpers for the flag selector datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

package flag_pkg;

    localparam int FLAG_SEL_W = 8;
    localparam int COLOR_W    = 6;

    typedef enum logic {
        MODE_AUTO = 1'b0,
        MODE_HOLD = 1'b1
    } mode_t;

    // Wrapping one-step move through 0..cnt-1; caller guarantees cur < cnt.
    function automatic logic [FLAG_SEL_W-1:0] step_index(
        input logic [FLAG_SEL_W-1:0] cur,
        input logic [FLAG_SEL_W-1:0] cnt,
        input logic                  fwd
    );
        logic [FLAG_SEL_W-1:0] last;
        last = cnt - FLAG_SEL_W'(1);
        if (fwd) begin
            return (cur == last) ? '0 : cur + FLAG_SEL_W'(1);
        end
        return (cur == '0) ? last : cur - FLAG_SEL_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/flag_selector_debounce.sv
// ============================================================================
// button_debounce : 2-FF synchroniser plus frame-rate debouncer, press pulse
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic frame_tick,
    output logic press
);

    localparam int DB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_FRAMES - 1);

    logic [1:0]      sync;
    logic            level;
    logic [DB_W-1:0] mismatch_cnt;
    logic            synced;
    logic            accept;

    assign synced = sync[1];
    assign accept = frame_tick && (synced != level) && (mismatch_cnt == DB_LAST);

    // Combinational so the top acts on the very tick the level is accepted.
    assign press = accept && synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync         <= 2'b00;
            level        <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (frame_tick) begin
                if (accept) begin
                    level        <= synced;
                    mismatch_cnt <= '0;
                end else if (synced != level) begin
                    mismatch_cnt <= mismatch_cnt + DB_W'(1);
                end else begin
                    mismatch_cnt <= '0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/flag_selector.sv
// ============================================================================
// flag_selector : frame-aligned flag index controller with auto and hold modes
// Revision : 1.0
// ============================================================================
`default_nettype none

module flag_selector
    import flag_pkg::*;
#(
    parameter int AUTO_FRAMES     = 180,
    parameter int HOLD_FRAMES     = 600,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int CNT_W           = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  btn_next_raw,
    input  logic                  btn_prev_raw,
    input  logic                  auto_en,
    input  logic [FLAG_SEL_W-1:0] count,
    output logic [FLAG_SEL_W-1:0] selector,
    output logic                  flag_changed,
    output logic                  mode
);

    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    mode_t                 state_q,  state_nxt;
    logic [FLAG_SEL_W-1:0] sel_q,    sel_nxt;
    logic [CNT_W-1:0]      auto_cnt, auto_nxt;
    logic [CNT_W-1:0]      hold_cnt, hold_nxt;
    logic                  changed_q;

    logic                  press_next;
    logic                  press_prev;
    logic                  clamp;
    logic                  one_press;
    logic [FLAG_SEL_W-1:0] next_idx;
    logic [FLAG_SEL_W-1:0] prev_idx;

    button_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_db_next (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (btn_next_raw),
        .frame_tick (frame_tick),
        .press      (press_next)
    );

    button_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_db_prev (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (btn_prev_raw),
        .frame_tick (frame_tick),
        .press      (press_prev)
    );

    // count == 0 also lands here, which pins the selector at 0.
    assign clamp     = (sel_q >= count);
    assign one_press = press_next ^ press_prev;
    assign next_idx  = step_index(sel_q, count, 1'b1);
    assign prev_idx  = step_index(sel_q, count, 1'b0);

    always_comb begin
        state_nxt = state_q;
        sel_nxt   = sel_q;
        auto_nxt  = auto_cnt;
        hold_nxt  = hold_cnt;
        if (frame_tick) begin
            if (!clamp && one_press) begin
                sel_nxt   = press_next ? next_idx : prev_idx;
                state_nxt = MODE_HOLD;
                auto_nxt  = '0;
                hold_nxt  = '0;
            end else begin
                if (clamp) begin
                    sel_nxt = '0;
                end
                case (state_q)
                    MODE_AUTO: begin
                        if (!auto_en) begin
                            auto_nxt = '0;
                        end else if (auto_cnt == AUTO_LAST) begin
                            auto_nxt = '0;
                            if (!clamp) begin
                                sel_nxt = next_idx;
                            end
                        end else begin
                            auto_nxt = auto_cnt + CNT_W'(1);
                        end
                    end
                    MODE_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_nxt = MODE_AUTO;
                            hold_nxt  = '0;
                            auto_nxt  = '0;
                        end else begin
                            hold_nxt = hold_cnt + CNT_W'(1);
                        end
                    end
                    default: state_nxt = MODE_AUTO;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MODE_AUTO;
            sel_q     <= '0;
            auto_cnt  <= '0;
            hold_cnt  <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            sel_q     <= sel_nxt;
            auto_cnt  <= auto_nxt;
            hold_cnt  <= hold_nxt;
            changed_q <= (sel_nxt != sel_q);
        end
    end

    assign selector     = sel_q;
    assign flag_changed = changed_q;
    assign mode         = (state_q == MODE_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_flag_selector.sv
// ============================================================================
// tb_flag_selector : directed + randomized bench against a behavioural model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_flag_selector;

    localparam int AF = 4;
    localparam int HF = 8;
    localparam int DF = 2;
    localparam int FRAME_CYC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_next_raw = 1'b0;
    logic       btn_prev_raw = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] count = 8'd36;
    logic [7:0] selector;
    logic       flag_changed;
    logic       mode;

    always #5 clk = ~clk;

    flag_selector #(
        .AUTO_FRAMES     (AF),
        .HOLD_FRAMES     (HF),
        .DEBOUNCE_FRAMES (DF),
        .CNT_W           (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .btn_next_raw (btn_next_raw),
        .btn_prev_raw (btn_prev_raw),
        .auto_en      (auto_en),
        .count        (count),
        .selector     (selector),
        .flag_changed (flag_changed),
        .mode         (mode)
    );

    int checks = 0;
    int failures = 0;
    int chg_seen = 0;
    int fphase = 0;

    // Behavioural model state
    int m_sel, m_mode, m_auto, m_hold, m_fc;
    int raw_hist[2][2];   // [button][edges ago - 1]
    int d_lvl[2];
    int d_run[2];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_mode = 0; m_auto = 0; m_hold = 0; m_fc = 0;
        for (int b = 0; b < 2; b++) begin
            raw_hist[b][0] = 0; raw_hist[b][1] = 0;
            d_lvl[b] = 0; d_run[b] = 0;
        end
    endtask

    task automatic db_step(input int b, output int pressed);
        int s;
        s = raw_hist[b][1];
        pressed = 0;
        if (s != d_lvl[b]) begin
            d_run[b]++;
            if (d_run[b] == DF) begin
                d_lvl[b] = s;
                d_run[b] = 0;
                pressed = (s == 1) ? 1 : 0;
            end
        end else begin
            d_run[b] = 0;
        end
    endtask

    task automatic model_step();
        int pn, pp, old, cnt;
        bit suppress, normal;
        old = m_sel;
        cnt = int'(count);
        if (rst_n == 1'b0) begin
            model_reset();
        end else begin
            if (frame_tick) begin
                db_step(0, pn);
                db_step(1, pp);
                suppress = 0;
                normal = 1;
                if (cnt == 0 || m_sel >= cnt) begin
                    m_sel = 0;
                    suppress = 1;
                end else if (pn != pp) begin
                    m_sel = (pn == 1) ? (m_sel + 1) % cnt : (m_sel + cnt - 1) % cnt;
                    m_mode = 1; m_auto = 0; m_hold = 0;
                    normal = 0;
                end
                if (normal) begin
                    if (m_mode == 0) begin
                        if (auto_en) begin
                            m_auto++;
                            if (m_auto == AF) begin
                                m_auto = 0;
                                if (!suppress) m_sel = (m_sel + 1) % cnt;
                            end
                        end else begin
                            m_auto = 0;
                        end
                    end else begin
                        m_hold++;
                        if (m_hold == HF) begin
                            m_mode = 0; m_hold = 0; m_auto = 0;
                        end
                    end
                end
            end
            for (int b = 0; b < 2; b++) raw_hist[b][1] = raw_hist[b][0];
            raw_hist[0][0] = int'(btn_next_raw);
            raw_hist[1][0] = int'(btn_prev_raw);
            m_fc = (m_sel != old) ? 1 : 0;
        end
    endtask

    task automatic cycle();
        frame_tick = (fphase == FRAME_CYC - 1);
        fphase = (fphase + 1) % FRAME_CYC;
        model_step();
        @(posedge clk);
        #1;
        if (flag_changed) chg_seen++;
        check("sel", int'(selector), m_sel);
        check("mode", int'(mode), m_mode);
        check("chg", int'(flag_changed), m_fc);
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME_CYC) cycle();
    endtask

    task automatic align();
        while (fphase != 0) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_sel", int'(selector), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_chg", int'(flag_changed), 0);
        cycle();
        rst_n = 1'b1;
    endtask

    // Raw level held 8 cycles spans exactly two ticks once synchronised.
    task automatic press(input logic n, input logic p);
        align();
        btn_next_raw = n;
        btn_prev_raw = p;
        repeat (8) cycle();
        btn_next_raw = 1'b0;
        btn_prev_raw = 1'b0;
        repeat (12) cycle();
    endtask

    initial begin
        int c0, r;
        model_reset();
        #1;
        check("init_sel", int'(selector), 0);
        check("init_mode", int'(mode), 0);
        check("init_chg", int'(flag_changed), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Auto advance and wrap
        auto_en = 1'b1;
        c0 = chg_seen;
        frames(4);
        check("auto_first", int'(selector), 1);
        check("auto_pulses", chg_seen - c0, 1);
        frames(140);
        check("auto_wrap", int'(selector), 0);
        frames(28);
        check("pre_reset_sel", int'(selector), 7);
        do_reset();

        // Debounce: one tick rejected, two ticks accepted
        auto_en = 1'b0;
        align();
        btn_next_raw = 1'b1;
        repeat (4) cycle();
        btn_next_raw = 1'b0;
        repeat (12) cycle();
        check("short_sel", int'(selector), 0);
        check("short_mode", int'(mode), 0);
        press(1'b1, 1'b0);
        check("press_sel", int'(selector), 1);
        check("press_mode", int'(mode), 1);
        auto_en = 1'b1;
        frames(HF - 3);
        check("hold_exit", int'(mode), 0);
        check("hold_exit_sel", int'(selector), 1);
        frames(AF);
        check("auto_resume", int'(selector), 2);

        // Wrap by buttons and cancellation
        auto_en = 1'b0;
        do_reset();
        press(1'b0, 1'b1);
        check("prev_wrap", int'(selector), 35);
        press(1'b1, 1'b0);
        check("next_wrap", int'(selector), 0);
        align();
        btn_next_raw = 1'b1;
        btn_prev_raw = 1'b1;
        repeat (8) cycle();
        check("both_sel", int'(selector), 0);
        check("both_mode", int'(mode), 1);
        btn_next_raw = 1'b0;
        btn_prev_raw = 1'b0;
        repeat (12) cycle();

        // Count shrink clamp and count == 0
        do_reset();
        auto_en = 1'b1;
        frames(80);
        check("sel20", int'(selector), 20);
        auto_en = 1'b0;
        count = 8'd10;
        c0 = chg_seen;
        frames(1);
        check("clamp_sel", int'(selector), 0);
        check("clamp_pulse", chg_seen - c0, 1);
        count = 8'd0;
        auto_en = 1'b1;
        press(1'b1, 1'b0);
        frames(10);
        check("cnt0_sel", int'(selector), 0);
        check("cnt0_mode", int'(mode), 0);

        // count == 1
        do_reset();
        count = 8'd1;
        c0 = chg_seen;
        press(1'b1, 1'b0);
        check("cnt1_sel", int'(selector), 0);
        check("cnt1_mode", int'(mode), 1);
        check("cnt1_pulses", chg_seen - c0, 0);

        // Randomized traffic
        count = 8'd36;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset();
            end else if (r < 15) begin
                case ($urandom_range(0, 5))
                    0: count = 8'd0;
                    1: count = 8'd1;
                    2: count = 8'd2;
                    3: count = 8'd3;
                    4: count = 8'd36;
                    default: count = 8'($urandom_range(0, 255));
                endcase
            end else if (r < 22) begin
                auto_en = 1'($urandom_range(0, 1));
            end
            btn_next_raw = ($urandom_range(0, 3) == 0);
            btn_prev_raw = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 12)) cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
